// File: rtl/pool_bram_arbiter.sv
// Two-requester round-robin arbiter with burst lock for one single-port pooling BRAM.
// Drives the BRAM port from registers and routes read data back to the issuing requester.
module pool_bram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 2,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              bram_en,
    output logic              bram_ren,
    output logic              bram_wen,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers in the cycle where valid && ready; valid and its
    // payload stay stable until then, and ready never looks at its own requester's ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_lock_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic               r_last;
    logic               w_cap;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_acc;
    logic               w_sel;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;

    logic               r_en;
    logic               r_ren;
    logic               r_wen;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_din;
    logic               r_cmd_id;
    logic [RD_LAT-1:0]  r_tag_v;
    logic [RD_LAT-1:0]  r_tag_id;
    logic               r_rvalid0;
    logic               r_rvalid1;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;

    assign w_cap = (r_lock_cnt == LOCK_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lock_cnt <= '0;
            r_last     <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_lock_cnt <= w_next_cnt;
            if (w_acc) begin
                r_last <= w_sel;
            end
        end
    end

    // Next-state logic; the cap only forces an exit while the other side is waiting
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_lock_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_ready0 && req0_lock) begin
                    w_next_state = S_OWN0;
                    w_next_cnt   = CNT_ONE;
                end else if (w_ready1 && req1_lock) begin
                    w_next_state = S_OWN1;
                    w_next_cnt   = CNT_ONE;
                end
            end
            S_OWN0: begin
                if (!req0_valid || (w_cap && req1_valid) || (w_ready0 && !req0_lock)) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else if (w_ready0 && !w_cap) begin
                    w_next_cnt = r_lock_cnt + CNT_ONE;
                end
            end
            S_OWN1: begin
                if (!req1_valid || (w_cap && req0_valid) || (w_ready1 && !req1_lock)) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else if (w_ready1 && !w_cap) begin
                    w_next_cnt = r_lock_cnt + CNT_ONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Output logic: grant decision
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready0 = req0_valid && (!req1_valid || r_last);
                w_ready1 = req1_valid && (!req0_valid || !r_last);
            end
            S_OWN0:  w_ready0 = req0_valid && !(w_cap && req1_valid);
            S_OWN1:  w_ready1 = req1_valid && !(w_cap && req0_valid);
            default: ;
        endcase
    end

    assign w_acc   = w_ready0 | w_ready1;
    assign w_sel   = w_ready1;
    assign w_we    = w_sel ? req1_we    : req0_we;
    assign w_addr  = w_sel ? req1_addr  : req0_addr;
    assign w_wdata = w_sel ? req1_wdata : req0_wdata;

    // Registered BRAM command; addr/din hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= 1'b0;
            r_ren    <= 1'b0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_cmd_id <= 1'b0;
        end else if (w_acc) begin
            r_en     <= 1'b1;
            r_ren    <= !w_we;
            r_wen    <= w_we;
            r_addr   <= w_addr;
            r_din    <= w_wdata;
            r_cmd_id <= w_sel;
        end else begin
            r_en  <= 1'b0;
            r_ren <= 1'b0;
            r_wen <= 1'b0;
        end
    end

    // Read tags follow the command through the BRAM latency; the last stage lines up with bram_dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= r_ren;
            r_tag_id[0] <= r_cmd_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= r_tag_v[RD_LAT-1] && !r_tag_id[RD_LAT-1];
            r_rvalid1 <= r_tag_v[RD_LAT-1] &&  r_tag_id[RD_LAT-1];
            if (r_tag_v[RD_LAT-1] && !r_tag_id[RD_LAT-1]) begin
                r_rdata0 <= bram_dout;
            end
            if (r_tag_v[RD_LAT-1] && r_tag_id[RD_LAT-1]) begin
                r_rdata1 <= bram_dout;
            end
        end
    end

    assign req0_ready  = w_ready0;
    assign req1_ready  = w_ready1;
    assign req0_rvalid = r_rvalid0;
    assign req1_rvalid = r_rvalid1;
    assign req0_rdata  = r_rdata0;
    assign req1_rdata  = r_rdata1;
    assign bram_en     = r_en;
    assign bram_ren    = r_ren;
    assign bram_wen    = r_wen;
    assign bram_addr   = r_addr;
    assign bram_din    = r_din;
    assign busy        = r_ren | (|r_tag_v) | r_rvalid0 | r_rvalid1;
    assign dbg_state   = r_state;

endmodule

// File: doc/pool_bram_arbiter.md
# pool_bram_arbiter

Two-requester arbiter and sequencer for one single-port pooling BRAM. Requester 0 is the pooling engine, which writes pooled results. Requester 1 is the inference/readback path, which reads results out while pooling is still running. The block grants one BRAM operation per cycle using round-robin with optional burst lock, drives the shared BRAM port from registers, and returns read data to the issuing requester after the fixed BRAM read latency. It sits between both requesters and the output BRAM instance.

## Interface
Parameters:
- ADDR_W, 16, BRAM address width
- DATA_W, 8, BRAM data width
- RD_LAT, 2, cycles from the BRAM command cycle to valid bram_dout (≥1)
- MAX_LOCK, 16, maximum consecutive grants to one locked requester while the other is waiting

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request pending, N∈{0,1}; held stable until accepted
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  address
- reqN_wdata  in  DATA_W  write data
- reqN_lock  in  1  keep the grant on following cycles (burst)
- reqN_ready  out  1  combinational; request accepted this cycle when valid && ready
- reqN_rvalid  out  1  one-cycle pulse, read data valid
- reqN_rdata  out  DATA_W  read data, held until the next rvalid for N
- bram_en, bram_ren, bram_wen  out  1  BRAM port controls (en = ren | wen)
- bram_addr  out  ADDR_W  BRAM address
- bram_din  out  DATA_W  BRAM write data
- bram_dout  in  DATA_W  BRAM read data
- busy  out  1  any read outstanding in the return pipeline

## Operation
- Arbiter states: IDLE, OWN0, OWN1. State OWNn means requester n holds a lock.
- IDLE: if one requester is valid, grant it. If both are valid, grant the one not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- An accepted request with lock=1 moves the arbiter to OWNn and clears lock_cnt to 1.
- OWNn: only requester n may be granted. On each grant lock_cnt increments.
- OWNn exits to IDLE when lock=0 at an accepted request, or when requester n is not valid.
- OWNn also exits to IDLE when lock_cnt==MAX_LOCK and the other requester is valid. The other requester then wins the next arbitration.
- lock_cnt is ADDR_W-independent and sized to hold MAX_LOCK. It saturates and never wraps.
- Accepted op is registered onto the BRAM port the next cycle: en=1, ren=!we, wen=we, addr, din.
- When no op is accepted, the next cycle drives en=ren=wen=0. addr and din hold their previous values.
- Each read pushes a tag (requester id) into an RD_LAT-deep shift pipeline. On the tag's exit, bram_dout is registered into reqN_rdata and reqN_rvalid pulses.
- Reads and writes are executed in acceptance order. A read issued after a write to the same address returns the new data; no bypass logic is required.
- Writes produce no response.

## Timing
- Reset values:
  - ready: combinational; with no valid inputs, both are 0.
  - rvalid 0, rdata 0.
  - bram_en, bram_ren, bram_wen 0; bram_addr 0, bram_din 0.
  - busy 0, state IDLE, lock_cnt 0, pipeline tags invalid.
- Accept in cycle t → BRAM command in cycle t+1 → bram_dout valid in cycle t+1+RD_LAT → reqN_rvalid in cycle t+2+RD_LAT. With RD_LAT=2, rvalid is at t+4.
- Throughput is one op per cycle. Back-to-back reads from alternating requesters return in order, one rvalid per cycle.
- reqN_ready depends only on valid inputs, state, pointer and lock_cnt. It never depends on ready of the same requester.
- If both are valid and the arbiter is in IDLE, exactly one ready is asserted.
- Reset mid-operation:
  - All outstanding reads are dropped; no rvalid is issued after rst_n rises.
  - The BRAM port deasserts immediately (asynchronously).
- Deassertion of valid without acceptance is a protocol violation. Behaviour then is don't-care, except that no BRAM write occurs unless the request was accepted.
- busy is high from the cycle after a read is accepted until the cycle its rvalid pulses.

## Test plan
- Reset check: assert rst_n=0 mid-stream with 2 reads in flight → bram_en=0 the same cycle, and no rvalid for 10 cycles after release.
- Single read: req1 reads addr 5 (BRAM holds 0x3C), accepted at t → bram_ren=1, addr=5 at t+1; req1_rvalid=1, rdata=0x3C at t+4; busy high from t+1 through t+4.
- Round-robin: both valid continuously, no lock, 6 cycles → grants alternate 0,1,0,1,0,1; req0 wins the first tie after reset.
- Lock and starvation cap (MAX_LOCK=4):
  - req0 locked writes to addr 0..9 while req1 is valid → req0 granted 4 cycles, then req1 once, then req0 4 more cycles.
  - Final BRAM contents at addr 0..9 match the written data.
- Write-then-read ordering: req0 writes 0xA5 to addr 9 at t, req1 reads addr 9 at t+1 → req1_rdata=0xA5 at t+5.
- Pipelined mixed reads: req0 reads addr 1 and 2, req1 reads addr 3, on consecutive cycles (BRAM holds 0x11, 0x22, 0x33) → rvalids on 3 consecutive cycles in order 0,0,1 with data 0x11, 0x22, 0x33.
